// File: rtl/sys_defs.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN             : machine word / address width
//   DEFAULT_FB_DEPTH : default number of fetch-buffer entries
//   IF_PACKET        : fetch-to-decode packet {valid, inst, pc, npc}
//   align_word       : clears the byte-offset bits of an address
package sys_defs;

   localparam int XLEN = 32;
   localparam int DEFAULT_FB_DEPTH = 4;

   typedef struct packed {
      logic            valid;
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] npc;
   } IF_PACKET;

   // Instructions are word aligned, so the low two address bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer holding {pc, inst} pairs between the I-cache and decode.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   flush             : discard every entry (takes priority over push/pop)
//   push, push_pc,
//   push_inst         : write one entry at the tail
//   pop               : retire the head entry
//   head_pc, head_inst: contents of the head entry (meaningless when empty)
//   count             : number of occupied entries
//   empty, full       : occupancy flags
module fetch_buffer
   import sys_defs::*;
#(
   parameter int DEPTH = DEFAULT_FB_DEPTH
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [XLEN-1:0]          push_pc,
   input  logic [31:0]              push_inst,
   input  logic                     pop,
   output logic [XLEN-1:0]          head_pc,
   output logic [31:0]              head_inst,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [XLEN-1:0]  pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Storage needs no reset: entries are only observed through head/count.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         pc_mem[tail]   <= push_pc;
         inst_mem[tail] <= push_inst;
      end
   end

   // Pointers are a power-of-two width, so incrementing wraps on its own.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_pc   = pc_mem[head];
   assign head_inst = inst_mem[head];
   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage sitting in front of the instruction cache.
// Ports:
//   clock, reset           : rising-edge clock, asynchronous active-low reset
//   Icache2proc_data/valid : cache response for the current fetch address
//   proc2Icache_addr       : registered fetch PC presented to the cache
//   branch_redirect_en,
//   branch_target_pc       : flush the buffer and restart fetch at the target
//   id_ready               : decode accepts the head instruction
//   if_packet_valid, if_inst,
//   if_pc, if_npc          : head instruction handed to decode
//   fb_count               : fetch-buffer occupancy
//   if_miss_cycles         : saturating count of cache-miss cycles not caused by backpressure
module fetch_unit
   import sys_defs::*;
#(
   parameter int              FB_DEPTH = DEFAULT_FB_DEPTH,
   parameter logic [XLEN-1:0] RESET_PC = '0
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic [XLEN-1:0]            Icache2proc_data,
   input  logic                       Icache2proc_valid,
   output logic [XLEN-1:0]            proc2Icache_addr,
   input  logic                       branch_redirect_en,
   input  logic [XLEN-1:0]            branch_target_pc,
   input  logic                       id_ready,
   output logic                       if_packet_valid,
   output logic [31:0]                if_inst,
   output logic [XLEN-1:0]            if_pc,
   output logic [XLEN-1:0]            if_npc,
   output logic [$clog2(FB_DEPTH):0]  fb_count,
   output logic [31:0]                if_miss_cycles
);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] head_pc;
   logic [31:0]     head_inst;
   logic            fb_empty;
   logic            fb_full;
   logic            push;
   logic            pop;
   logic            has_room;
   logic            miss;
   IF_PACKET        head_packet;

   // A pop frees a slot in the same edge, so a full buffer can still accept a hit.
   assign has_room = !fb_full || pop;
   assign pop      = if_packet_valid && id_ready;
   assign push     = Icache2proc_valid && !branch_redirect_en && has_room;
   assign miss     = !Icache2proc_valid && !branch_redirect_en && has_room;

   fetch_buffer #(
      .DEPTH(FB_DEPTH)
   ) buffer (
      .clock    (clock),
      .reset    (reset),
      .flush    (branch_redirect_en),
      .push     (push),
      .push_pc  (fetch_pc),
      .push_inst(Icache2proc_data[31:0]),
      .pop      (pop),
      .head_pc  (head_pc),
      .head_inst(head_inst),
      .count    (fb_count),
      .empty    (fb_empty),
      .full     (fb_full)
   );

   // Fetch PC: redirect wins; otherwise advance only when the word was captured,
   // so a miss or a full buffer keeps re-presenting the same address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
      end else if (branch_redirect_en) begin
         fetch_pc <= align_word(branch_target_pc);
      end else if (push) begin
         fetch_pc <= fetch_pc + XLEN'(4);
      end
   end

   // Miss counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_miss_cycles <= '0;
      end else if (miss && (if_miss_cycles != 32'hFFFF_FFFF)) begin
         if_miss_cycles <= if_miss_cycles + 32'd1;
      end
   end

   // Head packet: the valid bit is killed during a redirect so decode never
   // consumes a wrong-path instruction; payload is zeroed whenever the buffer is empty.
   always_comb begin
      head_packet       = '0;
      head_packet.valid = !fb_empty && !branch_redirect_en;
      if (!fb_empty) begin
         head_packet.inst = head_inst;
         head_packet.pc   = head_pc;
         head_packet.npc  = head_pc + XLEN'(4);
      end
   end

   assign proc2Icache_addr = fetch_pc;
   assign if_packet_valid  = head_packet.valid;
   assign if_inst          = head_packet.inst;
   assign if_pc            = head_packet.pc;
   assign if_npc           = head_packet.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural cache returns a word derived
// from the address, expected fetch PCs are queued as stimulus is set up and are
// popped whenever decode takes the head packet.
module tb_fetch_unit;
   import sys_defs::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        hit = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] target = '0;
   logic        ready = 1'b0;

   logic [31:0] data1, addr1, inst1, pc1, npc1, miss1;
   logic [31:0] data2, addr2, inst2, pc2, npc2, miss2;
   logic        valid1, valid2;
   logic [2:0]  count1, count2;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   always #5 clock = ~clock;

   // Cache contents model: every address holds a distinct, address-derived word.
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc ^ 32'h5A5A_0F0F) + 32'h0000_1111;
   endfunction

   assign data1 = inst_of(addr1);
   assign data2 = inst_of(addr2);

   fetch_unit #(.FB_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset),
      .Icache2proc_data(data1), .Icache2proc_valid(hit),
      .proc2Icache_addr(addr1),
      .branch_redirect_en(redirect), .branch_target_pc(target),
      .id_ready(ready),
      .if_packet_valid(valid1), .if_inst(inst1), .if_pc(pc1), .if_npc(npc1),
      .fb_count(count1), .if_miss_cycles(miss1)
   );

   fetch_unit #(.FB_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset(reset),
      .Icache2proc_data(data2), .Icache2proc_valid(hit),
      .proc2Icache_addr(addr2),
      .branch_redirect_en(redirect), .branch_target_pc(target),
      .id_ready(ready),
      .if_packet_valid(valid2), .if_inst(inst2), .if_pc(pc2), .if_npc(npc2),
      .fb_count(count2), .if_miss_cycles(miss2)
   );

   // Holds reset for two cycles, then releases it on a falling edge with the
   // requested cache/decode behaviour already applied.
   task automatic applyStimulus(input logic hit_v, input logic ready_v);
      @(negedge clock);
      reset = 1'b0;
      redirect = 1'b0;
      target = '0;
      hit = hit_v;
      ready = ready_v;
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b0;
      #1;
      tests_run++;
      if (addr1 !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_addr: got %h expected %h", addr1, 32'h0);
      end
      tests_run++;
      if (addr2 !== 32'hFFFF_FFF8) begin
         tests_failed++;
         $display("[TB] FAIL reset_addr_wrap: got %h expected %h", addr2, 32'hFFFF_FFF8);
      end
      tests_run++;
      if ({valid1, inst1, pc1, npc1, count1, miss1} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got valid=%b inst=%h pc=%h npc=%h count=%0d miss=%0d expected all zero",
                  valid1, inst1, pc1, npc1, count1, miss1);
      end
   endtask

   task automatic test_stream();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         tests_run++;
         if (valid1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stream_valid cycle %0d: got %b expected 1", c, valid1);
         end else begin
            exp_pc = exp_q.pop_front();
            tests_run++;
            if (pc1 !== exp_pc || inst1 !== inst_of(exp_pc) || npc1 !== exp_pc + 32'd4) begin
               tests_failed++;
               $display("[TB] FAIL stream_packet: got pc=%h inst=%h npc=%h expected pc=%h inst=%h npc=%h",
                        pc1, inst1, npc1, exp_pc, inst_of(exp_pc), exp_pc + 32'd4);
            end
         end
         tests_run++;
         if (count1 > 3'd1) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d expected at most 1", count1);
         end
      end
   endtask

   task automatic test_backpressure();
      applyStimulus(1'b1, 1'b0);
      repeat (6) @(negedge clock);
      tests_run++;
      if (count1 !== 3'd4 || addr1 !== 32'h10) begin
         tests_failed++;
         $display("[TB] FAIL full_hold: got count=%0d addr=%h expected count=4 addr=00000010", count1, addr1);
      end
      ready = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      for (int c = 0; c < 6; c++) begin
         tests_run++;
         if (valid1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drain_valid step %0d: got %b expected 1", c, valid1);
         end else begin
            exp_pc = exp_q.pop_front();
            if (pc1 !== exp_pc || inst1 !== inst_of(exp_pc)) begin
               tests_failed++;
               $display("[TB] FAIL drain_order: got pc=%h inst=%h expected pc=%h inst=%h",
                        pc1, inst1, exp_pc, inst_of(exp_pc));
            end
         end
         @(negedge clock);
      end
      tests_run++;
      if (addr1 !== 32'h28 || count1 !== 3'd4) begin
         tests_failed++;
         $display("[TB] FAIL resume_addr: got addr=%h count=%0d expected addr=00000028 count=4", addr1, count1);
      end
   endtask

   task automatic test_miss();
      applyStimulus(1'b1, 1'b1);
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      for (int n = 1; n <= 9; n++) begin
         @(negedge clock);
         if (valid1 === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL miss_extra_pop: got pc=%h expected no packet", pc1);
            end else begin
               exp_pc = exp_q.pop_front();
               if (pc1 !== exp_pc || inst1 !== inst_of(exp_pc)) begin
                  tests_failed++;
                  $display("[TB] FAIL miss_packet: got pc=%h inst=%h expected pc=%h inst=%h",
                           pc1, inst1, exp_pc, inst_of(exp_pc));
               end
            end
         end
         if (n >= 2 && n <= 7) begin
            tests_run++;
            if (addr1 !== 32'h8) begin
               tests_failed++;
               $display("[TB] FAIL miss_addr_hold cycle %0d: got %h expected 00000008", n, addr1);
            end
         end
         if (n == 2) hit = 1'b0;
         if (n == 7) begin
            hit = 1'b1;
            tests_run++;
            if (miss1 !== 32'd5) begin
               tests_failed++;
               $display("[TB] FAIL miss_count: got %0d expected 5", miss1);
            end
         end
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL miss_missing_pops: got %0d left expected 0", exp_q.size());
      end
   endtask

   task automatic test_redirect();
      applyStimulus(1'b1, 1'b0);
      repeat (3) @(negedge clock);
      tests_run++;
      if (count1 !== 3'd3 || valid1 !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL redirect_setup: got count=%0d valid=%b expected count=3 valid=1", count1, valid1);
      end
      redirect = 1'b1;
      target = 32'h1003;
      #1;
      tests_run++;
      if (valid1 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL redirect_kill_valid: got %b expected 0", valid1);
      end
      @(negedge clock);
      tests_run++;
      if (addr1 !== 32'h1000 || count1 !== 3'd0 || valid1 !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL redirect_flush: got addr=%h count=%0d valid=%b expected addr=00001000 count=0 valid=0",
                  addr1, count1, valid1);
      end
      redirect = 1'b0;
      ready = 1'b1;
      @(negedge clock);
      tests_run++;
      if (valid1 !== 1'b1 || pc1 !== 32'h1000 || inst1 !== inst_of(32'h1000)) begin
         tests_failed++;
         $display("[TB] FAIL redirect_target_head: got valid=%b pc=%h inst=%h expected valid=1 pc=00001000 inst=%h",
                  valid1, pc1, inst1, inst_of(32'h1000));
      end
   endtask

   task automatic test_wrap();
      applyStimulus(1'b1, 1'b1);
      exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         exp_pc = exp_q.pop_front();
         tests_run++;
         if (valid2 !== 1'b1 || pc2 !== exp_pc || npc2 !== exp_pc + 32'd4 || inst2 !== inst_of(exp_pc)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_packet: got valid=%b pc=%h npc=%h inst=%h expected pc=%h npc=%h inst=%h",
                     valid2, pc2, npc2, inst2, exp_pc, exp_pc + 32'd4, inst_of(exp_pc));
         end
      end
   endtask

   task automatic test_reset_midstream();
      applyStimulus(1'b1, 1'b0);
      repeat (2) @(negedge clock);
      tests_run++;
      if (count1 !== 3'd2) begin
         tests_failed++;
         $display("[TB] FAIL midstream_setup: got count=%0d expected 2", count1);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if ({valid1, inst1, pc1, npc1, count1, addr1} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midstream_reset: got valid=%b inst=%h pc=%h npc=%h count=%0d addr=%h expected all zero",
                  valid1, inst1, pc1, npc1, count1, addr1);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_miss();
      test_redirect();
      test_wrap();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
